mul_ctrl: RTL
=============

MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: "clk" and "reset".
REQ-002 The ports SHALL be as follows:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- flush  in  1  cancel any in-flight op (pipeline exception/ertn)
- req_valid  in  1  EX requests a multiply
- req_ready  out  1  controller accepts a request
- req_op  in  3  one-hot {mulh_wu, mulh_w, mul_w}
- req_src1  in  32  multiplicand
- req_src2  in  32  multiplier
- mul_x  out  34  operand x to the 2-stage booth multiplier
- mul_y  out  34  operand y to the booth multiplier
- mul_z  in  68  booth multiplier product; valid 1 clk after x/y are presented
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  32  selected result word
- busy  out  1  state != IDLE

Function
REQ-003 The block SHALL use a four-state FSM: IDLE, ISSUE, CAPT, DONE.
REQ-004 req_ready SHALL be 1 iff state==IDLE and flush==0 and reset==0 (combinational).
REQ-005 When req_valid&&req_ready, the block SHALL register operands and op, then go to ISSUE.
REQ-006 Operand extension SHALL be as follows:
- mul_w / mulh_w: mul_x={2{src1[31]},src1}, mul_y={2{src2[31]},src2}.
- mulh_wu: zero-extended, {2'b00,src}.
REQ-007 mul_x and mul_y SHALL be driven only from the operand registers and SHALL stay stable from ISSUE through CAPT.
REQ-008 ISSUE SHALL always go to CAPT after 1 cycle; the multiplier pipeline register captures at the end of ISSUE.
REQ-009 In CAPT, mul_z SHALL be sampled into a 32-bit result register, and the FSM SHALL go to DONE.
REQ-010 Result select SHALL be:
- mul_w -> mul_z[31:0]
- mulh_w or mulh_wu -> mul_z[63:32]
REQ-011 Op decode SHALL use the priority mul_w > mulh_w > mulh_wu when multiple bits are set; req_op==0 SHALL complete normally with res_data=0.
REQ-012 res_valid SHALL be 1 iff state==DONE; res_data SHALL equal the result register and SHALL hold stable while res_valid&&!res_ready.
REQ-013 In DONE, res_ready SHALL return the FSM to IDLE on the next edge; a new request is accepted no earlier than the cycle after.
REQ-014 Latency SHALL be fixed: acceptance at edge T gives res_valid high from T+3 (ISSUE T+1, CAPT T+2, DONE T+3), independent of data.
REQ-015 Throughput SHALL be at most 1 op per 4 cycles, with no overlapping ops.
REQ-016 flush in any state SHALL force IDLE at the next edge, with these consequences:
- res_valid drops that edge.
- The discarded result is never presented.
- No request is accepted in the flush cycle.
REQ-017 When flush and res_ready are both high in DONE, the flush SHALL take precedence; the outcome is IDLE either way and no second handshake is counted.
REQ-018 busy SHALL be 1 in ISSUE, CAPT and DONE, and 0 in IDLE.
REQ-019 The block SHALL NOT reset or clock-gate the multiplier; stale mul_z values outside CAPT are ignored.

Reset
REQ-020 Under reset the following SHALL hold:
- state=IDLE
- operand registers=0 (mul_x=mul_y=0)
- result register=0
- res_valid=0, busy=0, req_ready=0
REQ-021 req_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-022 Reset mid-operation SHALL discard the op with no res_valid pulse, and SHALL take precedence over flush and the handshakes.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- mul_w 3 x 5, accepted at T, res_ready=1 -> res_valid only at T+3, res_data=0x0000000F, busy 1 for T+1..T+3.
- mulh_w 0x80000000 x 0x80000000 -> 0x40000000; mulh_w 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; mul_w same operands -> 0x00000001.
- mulh_wu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mul_x=mul_y=0x0FFFFFFFF during ISSUE/CAPT.
- res_ready low 5 cycles in DONE, req_valid held high -> res_valid/res_data stable, req_ready=0 throughout; accept resumes the cycle after res_ready.
- flush asserted in CAPT -> IDLE next edge, res_valid never rises; flush with req_valid in IDLE -> not accepted.
- reset asserted in DONE (res_data=0x1234) -> res_valid=0, res_data=0 next edge; req_ready=1 the cycle after reset drops.

Source files
------------

// File: rtl/mul_ctrl.sv
// +--------------------------------------------------------------------------+
// | mul_ctrl : sequencing controller for an external 2-stage booth multiplier |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mul_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic [33:0] mul_x,
  output logic [33:0] mul_y,
  input  logic [67:0] mul_z,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [33:0] x_q;
  logic [33:0] y_q;
  logic [1:0]  sel_q;
  logic [31:0] res_q;

  logic        accept;
  logic        sext;
  logic [1:0]  sel_d;
  logic [31:0] res_nxt;
  logic        unused_z;

  // Product bits above 63 never feed a result word.
  assign unused_z = ^mul_z[67:64];

  assign req_ready = (state == IDLE) && !flush && !reset;
  assign accept    = req_valid && req_ready;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign res_data  = res_q;

  // Op decode with priority mul_w > mulh_w > mulh_wu; an empty op selects zero.
  always_comb begin
    sext  = req_op[0] | req_op[1];
    sel_d = SEL_NONE;
    if (req_op[0]) begin
      sel_d = SEL_LO;
    end else if (req_op[1] || req_op[2]) begin
      sel_d = SEL_HI;
    end
  end

  always_comb begin
    res_nxt = 32'd0;
    case (sel_q)
      SEL_LO:  res_nxt = mul_z[31:0];
      SEL_HI:  res_nxt = mul_z[63:32];
      default: res_nxt = 32'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x_q   <= 34'd0;
      y_q   <= 34'd0;
      sel_q <= SEL_NONE;
      res_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q   <= {{2{sext & req_src1[31]}}, req_src1};
        y_q   <= {{2{sext & req_src2[31]}}, req_src2};
        sel_q <= sel_d;
      end
      // Multiplier output is only meaningful one cycle after ISSUE.
      if (state == CAPT) begin
        res_q <= res_nxt;
      end
    end
  end

endmodule

`default_nettype wire
